// File: rtl/ttt_game_ctrl.sv
// rtl/ttt_game_ctrl.sv - tic-tac-toe engine: key debounce, move placement, win/draw detection
// Optional TTT_WIN_LINE_EN adds the win_line output flagging every completed line.
module ttt_game_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  key,
    input  logic        new_game,
    output logic [17:0] board,
    output logic        turn,
    output logic [1:0]  winner,
    output logic        draw,
    output logic        game_over,
    output logic        move_accepted,
    output logic        move_rejected
`ifdef TTT_WIN_LINE_EN
    ,
    output logic [7:0]  win_line
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;

    state_t           state;
    logic [8:0]       sync1, sync2, cand, deb, deb_prev;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       move_cnt;
    logic [3:0]       sel_idx;
    logic             one_hot, sel_empty, press_evt;
    logic [7:0]       line_x, line_o;

    // Bit order: row0,row1,row2,col0,col1,col2,diag(0,4,8),diag(2,4,6).
    function automatic logic [7:0] lines_of(input logic [17:0] b, input logic [1:0] p);
        logic [8:0] m;
        for (int k = 0; k < 9; k++) m[k] = (b[2*k +: 2] == p);
        return {m[2] & m[4] & m[6], m[0] & m[4] & m[8],
                m[2] & m[5] & m[8], m[1] & m[4] & m[7], m[0] & m[3] & m[6],
                m[6] & m[7] & m[8], m[3] & m[4] & m[5], m[0] & m[1] & m[2]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            cand     <= '0;
            cnt      <= '0;
            deb      <= '0;
            deb_prev <= '0;
        end else begin
            sync1    <= key;
            sync2    <= sync1;
            deb_prev <= deb;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= cand;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Only the 0 -> nonzero edge counts, so rollover to another key is ignored.
    assign press_evt = (deb_prev == 9'd0) && (deb != 9'd0);
    assign one_hot   = (deb != 9'd0) && ((deb & (deb - 9'd1)) == 9'd0);

    always_comb begin
        sel_idx = '0;
        for (int k = 0; k < 9; k++) begin
            if (deb[k]) sel_idx = 4'(k);
        end
    end

    assign sel_empty = (board[{sel_idx, 1'b0} +: 2] == 2'd0);
    assign line_x    = lines_of(board, 2'd1);
    assign line_o    = lines_of(board, 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= PLAY;
            board         <= '0;
            turn          <= 1'b0;
            winner        <= 2'd0;
            draw          <= 1'b0;
            game_over     <= 1'b0;
            move_cnt      <= '0;
            move_accepted <= 1'b0;
            move_rejected <= 1'b0;
        end else begin
            move_accepted <= 1'b0;
            move_rejected <= 1'b0;
            if (new_game) begin
                state     <= PLAY;
                board     <= '0;
                turn      <= 1'b0;
                winner    <= 2'd0;
                draw      <= 1'b0;
                game_over <= 1'b0;
                move_cnt  <= '0;
            end else begin
                case (state)
                    PLAY: begin
                        if (press_evt) begin
                            if (one_hot && sel_empty) begin
                                board[{sel_idx, 1'b0} +: 2] <= {turn, ~turn};
                                move_cnt      <= move_cnt + 4'd1;
                                move_accepted <= 1'b1;
                                state         <= CHECK;
                            end else begin
                                move_rejected <= 1'b1;
                            end
                        end
                    end
                    CHECK: begin
                        // Win is tested before the full-board draw.
                        if (|line_x) begin
                            winner    <= 2'd1;
                            game_over <= 1'b1;
                            state     <= OVER;
                        end else if (|line_o) begin
                            winner    <= 2'd2;
                            game_over <= 1'b1;
                            state     <= OVER;
                        end else if (move_cnt == 4'd9) begin
                            draw      <= 1'b1;
                            game_over <= 1'b1;
                            state     <= OVER;
                        end else begin
                            turn  <= ~turn;
                            state <= PLAY;
                        end
                    end
                    default: state <= OVER;
                endcase
            end
        end
    end

`ifdef TTT_WIN_LINE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_line <= '0;
        end else if (new_game) begin
            win_line <= '0;
        end else if (state == CHECK && (|line_x || |line_o)) begin
            win_line <= (|line_x) ? line_x : line_o;
        end
    end
`else
    // No completed-line register in this build.
`endif

endmodule
